// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM sequencing the shared ALU and unified memory
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Half,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Jal,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JREG   = 4'd12
  } state_e;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd8;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BNE = 4'd11;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_SLL = 4'd13;
  localparam logic [3:0] ALU_SRL = 4'd14;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  state_e state_q, state_d;

  logic is_load, is_store, is_imm, is_branch, is_jump, is_rtype, r_alu, r_jreg;

  // Instruction class decode from the IR fields
  always_comb begin
    is_load   = (opcode == OP_LW) || (opcode == OP_LH);
    is_store  = (opcode == OP_SW) || (opcode == OP_SH);
    is_imm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_SLTI);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
    is_rtype  = (opcode == OP_RTYPE);
    r_jreg    = (funct == FN_JR) || (funct == FN_JALR);
    r_alu     = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                (funct == FN_OR)  || (funct == FN_XOR) || (funct == FN_NOR) ||
                (funct == FN_SLT) || (funct == FN_SLL) || (funct == FN_SRL);
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state and datapath control; everything held at defaults while in reset
  always_comb begin
    state_d     = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Half        = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    Jal         = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_NOP;
    PCSource    = 2'b00;
    illegal     = 1'b0;
    instr_done  = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = ALU_ADD;
          if (is_load || is_store)      state_d = S_MEMADR;
          else if (is_imm)              state_d = S_IMMEX;
          else if (is_branch)           state_d = S_BRANCH;
          else if (is_jump)             state_d = S_JUMP;
          else if (is_rtype && r_jreg)  state_d = S_JREG;
          else if (is_rtype && r_alu)   state_d = S_EXEC;
          else                          illegal = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = ALU_ADD;
          state_d = is_store ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          Half    = (opcode == OP_LH);
          state_d = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          Half       = (opcode == OP_SH);
          instr_done = mem_ready;
          state_d    = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          state_d = S_ALUWB;
          case (funct)
            FN_ADD:  ALUOp = ALU_ADD;
            FN_SUB:  ALUOp = ALU_SUB;
            FN_AND:  ALUOp = ALU_AND;
            FN_OR:   ALUOp = ALU_OR;
            FN_XOR:  ALUOp = ALU_XOR;
            FN_NOR:  ALUOp = ALU_NOR;
            FN_SLT:  ALUOp = ALU_SLT;
            FN_SLL:  ALUOp = ALU_SLL;
            FN_SRL:  ALUOp = ALU_SRL;
            default: ALUOp = ALU_NOP;
          endcase
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_IMMWB;
          case (opcode)
            OP_ADDI: ALUOp = ALU_ADD;
            OP_ANDI: ALUOp = ALU_AND;
            OP_SLTI: ALUOp = ALU_SLT;
            default: ALUOp = ALU_NOP;
          endcase
        end
        S_IMMWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
          if (opcode == OP_JAL) begin
            RegWrite = 1'b1;
            Jal      = 1'b1;
          end
        end
        S_JREG: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b11;
          instr_done = 1'b1;
          if (funct == FN_JALR) begin
            RegWrite = 1'b1;
            Jal      = 1'b1;
            RegDst   = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, Half;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, Jal, illegal, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [21:0] cw;
  } exp_t;

  exp_t q[$];
  string cur_tag;

  logic [21:0] obs_cw;
  assign obs_cw = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, Half, MemToReg,
                   RegDst, RegWrite, ALUSrcA, Jal, ALUSrcB, ALUOp, PCSource, illegal, instr_done};

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Half(Half), .MemToReg(MemToReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Jal(Jal),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] mk(input logic pcw, pcwc, iord, irw, mrd, mwr, half, m2r,
                                     rdst, rw, srca, jal, input logic [1:0] srcb,
                                     input logic [3:0] aop, input logic [1:0] pcs,
                                     input logic ill, done);
    return {pcw, pcwc, iord, irw, mrd, mwr, half, m2r, rdst, rw, srca, jal, srcb, aop, pcs, ill, done};
  endfunction

  function automatic logic [21:0] w_reset();
    return mk(0,0,0,0,0,0,0,0,0,0,0,0, 2'b00, 4'd15, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_fetch(input logic mr);
    return mk(mr,0,0,mr,1,0,0,0,0,0,0,0, 2'b01, 4'd3, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_decode(input logic ill);
    return mk(0,0,0,0,0,0,0,0,0,0,0,0, 2'b11, 4'd3, 2'b00, ill, 0);
  endfunction
  function automatic logic [21:0] w_memadr();
    return mk(0,0,0,0,0,0,0,0,0,0,1,0, 2'b10, 4'd3, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_memrd(input logic h);
    return mk(0,0,1,0,1,0,h,0,0,0,0,0, 2'b00, 4'd15, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_memwb();
    return mk(0,0,0,0,0,0,0,1,0,1,0,0, 2'b00, 4'd15, 2'b00, 0, 1);
  endfunction
  function automatic logic [21:0] w_memwr(input logic h, input logic mr);
    return mk(0,0,1,0,0,1,h,0,0,0,0,0, 2'b00, 4'd15, 2'b00, 0, mr);
  endfunction
  function automatic logic [21:0] w_exec(input logic [3:0] a);
    return mk(0,0,0,0,0,0,0,0,0,0,1,0, 2'b00, a, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_aluwb();
    return mk(0,0,0,0,0,0,0,0,1,1,0,0, 2'b00, 4'd15, 2'b00, 0, 1);
  endfunction
  function automatic logic [21:0] w_immex(input logic [3:0] a);
    return mk(0,0,0,0,0,0,0,0,0,0,1,0, 2'b10, a, 2'b00, 0, 0);
  endfunction
  function automatic logic [21:0] w_immwb();
    return mk(0,0,0,0,0,0,0,0,0,1,0,0, 2'b00, 4'd15, 2'b00, 0, 1);
  endfunction
  function automatic logic [21:0] w_branch(input logic [3:0] a);
    return mk(0,1,0,0,0,0,0,0,0,0,1,0, 2'b00, a, 2'b01, 0, 1);
  endfunction
  function automatic logic [21:0] w_jump(input logic l);
    return mk(1,0,0,0,0,0,0,0,0,l,0,l, 2'b00, 4'd15, 2'b10, 0, 1);
  endfunction
  function automatic logic [21:0] w_jreg(input logic l);
    return mk(1,0,0,0,0,0,0,0,l,l,0,l, 2'b00, 4'd15, 2'b11, 0, 1);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] s, input logic [21:0] w);
    exp_t e;
    e.st = s;
    e.cw = w;
    q.push_back(e);
  endtask

  // Drive one cycle's inputs at the falling edge, then pop and compare mid-cycle
  task automatic cyc(input logic mr, input logic r);
    exp_t e;
    rst       = r;
    mem_ready = mr;
    #1;
    nchecks++;
    assert (q.size() != 0) else begin
      nerr++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", cur_tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      nchecks++;
      assert (state === e.st) else begin
        nerr++;
        $error("FAIL %s state: observed %0d expected %0d", cur_tag, state, e.st);
      end
      nchecks++;
      assert (obs_cw === e.cw) else begin
        nerr++;
        $error("FAIL %s controls: observed %b expected %b", cur_tag, obs_cw, e.cw);
      end
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int fw);
    opcode = op;
    funct  = fn;
    repeat (fw) begin
      push(4'd0, w_fetch(1'b0));
      cyc(1'b0, 1'b1);
    end
    push(4'd0, w_fetch(1'b1));
    cyc(1'b1, 1'b1);
    push(4'd1, w_decode(1'b0));
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_load(input logic [5:0] op, input logic h, input int fw, input int mw);
    cur_tag = h ? "lh" : "lw";
    fetch(op, 6'h15, fw);
    push(4'd2, w_memadr());
    cyc(rnd(), 1'b1);
    repeat (mw) begin
      push(4'd3, w_memrd(h));
      cyc(1'b0, 1'b1);
    end
    push(4'd3, w_memrd(h));
    cyc(1'b1, 1'b1);
    push(4'd4, w_memwb());
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_store(input logic [5:0] op, input logic h, input int mw);
    cur_tag = h ? "sh" : "sw";
    fetch(op, 6'h2a, 0);
    push(4'd2, w_memadr());
    cyc(rnd(), 1'b1);
    repeat (mw) begin
      push(4'd5, w_memwr(h, 1'b0));
      cyc(1'b0, 1'b1);
    end
    push(4'd5, w_memwr(h, 1'b1));
    cyc(1'b1, 1'b1);
  endtask

  task automatic t_rtype(input logic [5:0] fn, input logic [3:0] a);
    cur_tag = "rtype";
    fetch(6'b000000, fn, 0);
    push(4'd6, w_exec(a));
    cyc(rnd(), 1'b1);
    push(4'd7, w_aluwb());
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_imm(input logic [5:0] op, input logic [3:0] a);
    cur_tag = "imm";
    fetch(op, 6'h3f, 0);
    push(4'd10, w_immex(a));
    cyc(rnd(), 1'b1);
    push(4'd11, w_immwb());
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_branch(input logic [5:0] op, input logic [3:0] a);
    cur_tag = "branch";
    fetch(op, 6'h00, 0);
    push(4'd8, w_branch(a));
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_jump(input logic l);
    cur_tag = l ? "jal" : "j";
    fetch(l ? 6'b000011 : 6'b000010, 6'h09, 0);
    push(4'd9, w_jump(l));
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_jreg(input logic l);
    cur_tag = l ? "jalr" : "jr";
    fetch(6'b000000, l ? 6'b001001 : 6'b001000, 0);
    push(4'd12, w_jreg(l));
    cyc(rnd(), 1'b1);
  endtask

  task automatic t_illegal(input logic [5:0] op, input logic [5:0] fn);
    cur_tag = "illegal";
    opcode = op;
    funct  = fn;
    push(4'd0, w_fetch(1'b1));
    cyc(1'b1, 1'b1);
    push(4'd1, w_decode(1'b1));
    cyc(rnd(), 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'b0;
    funct     = 6'b0;
    cur_tag   = "reset";
    @(negedge clk);
    push(4'd0, w_reset());
    cyc(1'b1, 1'b0);
    push(4'd0, w_reset());
    cyc(1'b1, 1'b0);

    t_load(6'b100011, 1'b0, 0, 0);
    t_store(6'b101001, 1'b1, 2);
    t_rtype(6'b100110, 4'd8);
    t_jreg(1'b1);
    t_branch(6'b000101, 4'd11);
    t_jump(1'b1);

    t_rtype(6'b100000, 4'd3);
    t_rtype(6'b100010, 4'd6);
    t_rtype(6'b100100, 4'd0);
    t_rtype(6'b100101, 4'd1);
    t_rtype(6'b100111, 4'd12);
    t_rtype(6'b101010, 4'd7);
    t_rtype(6'b000000, 4'd13);
    t_rtype(6'b000010, 4'd14);
    t_imm(6'b001000, 4'd3);
    t_imm(6'b001100, 4'd0);
    t_imm(6'b001010, 4'd7);
    t_branch(6'b000100, 4'd10);
    t_jump(1'b0);
    t_jreg(1'b0);
    t_store(6'b101011, 1'b0, 0);
    t_load(6'b100001, 1'b1, 1, 2);

    t_illegal(6'b111111, 6'b000000);
    t_illegal(6'b000000, 6'b111111);
    t_imm(6'b001000, 4'd3);

    // Reset while a load waits in MEMRD: outputs drop at once, no write follows
    t_load(6'b100011, 1'b0, 0, 0);
    cur_tag = "reset_mid";
    fetch(6'b100011, 6'h00, 0);
    push(4'd2, w_memadr());
    cyc(1'b1, 1'b1);
    push(4'd3, w_memrd(1'b0));
    cyc(1'b0, 1'b1);
    push(4'd3, w_reset());
    cyc(1'b0, 1'b0);
    push(4'd0, w_reset());
    cyc(1'b1, 1'b0);
    push(4'd0, w_reset());
    cyc(1'b1, 1'b0);
    t_imm(6'b001010, 4'd7);
    t_load(6'b100011, 1'b0, 2, 1);

    nchecks++;
    assert (q.size() == 0) else begin
      nerr++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
